// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline register enables, bubble/flush control, halt drain and stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             readEnX,
  input  logic [2:0]       wrtRegX,
  input  logic [2:0]       srcAD,
  input  logic             srcAValidD,
  input  logic [2:0]       srcBD,
  input  logic             srcBValidD,
  input  logic             branchTakenX,
  input  logic             haltD,
  input  logic             iMemStall,
  input  logic             dMemStall,
  output logic             pcEn,
  output logic             enFD,
  output logic             flushFD,
  output logic             enDX,
  output logic             bubbleDX,
  output logic             enXM,
  output logic             enMW,
  output logic             halted,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t r_state, w_next;
  logic [1:0] r_drain, w_drain_next;
  logic r_halted, w_lu_haz, w_stall_inc, w_flush_inc;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  assign w_lu_haz = readEnX & ((srcAValidD & (srcAD == wrtRegX)) | (srcBValidD & (srcBD == wrtRegX)));
  always_comb begin
    {pcEn, enFD, flushFD, enDX, bubbleDX, enXM, enMW} = 7'b0;
    w_next = r_state;
    w_drain_next = r_drain;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    if (!rst && !dMemStall) begin
      case (r_state)
        RUN: begin
          {enDX, enXM, enMW} = 3'b111;
          if (branchTakenX) begin
            {pcEn, enFD, flushFD, bubbleDX} = 4'b1111;
            w_flush_inc = 1'b1;
          end else if (w_lu_haz) begin
            bubbleDX = 1'b1;
            w_stall_inc = 1'b1;
          end else if (haltD) begin
            {pcEn, enFD} = 2'b11;
            w_next = DRAIN;
            w_drain_next = 2'(DRAIN_CYC);
          end else begin
            // An I-mem miss holds PC and feeds a NOP into F/D while older work advances.
            {pcEn, enFD, flushFD} = iMemStall ? 3'b011 : 3'b110;
            w_stall_inc = iMemStall;
          end
        end
        DRAIN: begin
          {enFD, flushFD, enDX, bubbleDX, enXM, enMW} = 6'b111111;
          w_drain_next = r_drain - 2'd1;
          w_next = (r_drain == 2'd1) ? HALTED : DRAIN;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_drain     <= 2'd0;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_drain  <= w_drain_next;
      r_halted <= (w_next == HALTED);
      if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end
  assign halted   = r_halted;
  assign stallCnt = r_stall_cnt;
  assign flushCnt = r_flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed plan scenarios plus randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int CNT_W = 4;
  localparam int DRAIN_CYC = 3;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 0, rst = 0;
  logic readEnX, srcAValidD, srcBValidD, branchTakenX, haltD, iMemStall, dMemStall;
  logic [2:0] wrtRegX, srcAD, srcBD;
  logic pcEn, enFD, flushFD, enDX, bubbleDX, enXM, enMW, halted;
  logic [CNT_W-1:0] stallCnt, flushCnt;
  int n_tests = 0, n_fail = 0;
  int m_mode, m_drain, m_stall, m_flush, halt_age;
  bit m_halted;
  pipe_hazard_ctrl #(.CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk(clk), .rst(rst), .readEnX(readEnX), .wrtRegX(wrtRegX), .srcAD(srcAD),
    .srcAValidD(srcAValidD), .srcBD(srcBD), .srcBValidD(srcBValidD),
    .branchTakenX(branchTakenX), .haltD(haltD), .iMemStall(iMemStall), .dMemStall(dMemStall),
    .pcEn(pcEn), .enFD(enFD), .flushFD(flushFD), .enDX(enDX), .bubbleDX(bubbleDX),
    .enXM(enXM), .enMW(enMW), .halted(halted), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit lu();
    return readEnX && ((srcAValidD && srcAD == wrtRegX) || (srcBValidD && srcBD == wrtRegX));
  endfunction
  // Expected {pcEn,enFD,flushFD,enDX,bubbleDX,enXM,enMW} for the current cycle.
  function automatic logic [6:0] exp_out();
    if (dMemStall) return 7'b0000000;
    if (m_mode == 1) return 7'b0111111;
    if (m_mode == 2) return 7'b0000000;
    if (branchTakenX) return 7'b1111111;
    if (lu()) return 7'b0001111;
    if (!haltD && iMemStall) return 7'b0111011;
    return 7'b1101011;
  endfunction
  task automatic model_step();
    if (m_mode == 0 && !dMemStall) begin
      if (branchTakenX) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      else if (lu()) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      else if (haltD) begin
        m_mode = 1;
        m_drain = DRAIN_CYC;
      end else if (iMemStall) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end else if (m_mode == 1 && !dMemStall) begin
      m_drain--;
      if (m_drain == 0) m_mode = 2;
    end
    m_halted = (m_mode == 2);
  endtask
  task automatic step();
    #3;
    chk("outs", {pcEn, enFD, flushFD, enDX, bubbleDX, enXM, enMW}, exp_out());
    @(posedge clk);
    model_step();
    #1;
    chk("halted", halted, m_halted);
    chk("stallCnt", stallCnt, m_stall);
    chk("flushCnt", flushCnt, m_flush);
  endtask
  task automatic do_reset();
    rst = 1;
    #1;
    chk("rst_outs", {pcEn, enFD, flushFD, enDX, bubbleDX, enXM, enMW}, 7'b0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stallCnt, 0);
    chk("rst_flush", flushCnt, 0);
    m_mode = 0; m_drain = 0; m_stall = 0; m_flush = 0; m_halted = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic idle();
    {readEnX, srcAValidD, srcBValidD, branchTakenX, haltD, iMemStall, dMemStall} = 7'b0;
    wrtRegX = 3'd0; srcAD = 3'd1; srcBD = 3'd2;
  endtask
  initial begin
    idle();
    #1;
    do_reset();
    step();
    readEnX = 1; wrtRegX = 3; srcAD = 3; srcAValidD = 1;
    step();
    readEnX = 0;
    step();
    chk("lu_stallCnt", stallCnt, 1);
    readEnX = 1; branchTakenX = 1;
    step();
    chk("br_lu_flushCnt", flushCnt, 1);
    branchTakenX = 0; dMemStall = 1;
    repeat (4) step();
    dMemStall = 0;
    step();
    readEnX = 0; haltD = 1;
    step();
    haltD = 0;
    step();
    dMemStall = 1;
    repeat (2) step();
    dMemStall = 0;
    repeat (2) step();
    chk("drain_halted", halted, 1);
    repeat (2) step();
    do_reset();
    haltD = 1; branchTakenX = 1;
    step();
    idle();
    repeat (4) step();
    iMemStall = 1;
    repeat (20) step();
    chk("stall_sat", stallCnt, CMAX);
    idle(); haltD = 1;
    step();
    haltD = 0;
    step();
    do_reset();
    halt_age = 0;
    for (int i = 0; i < 3000; i++) begin
      readEnX = ($urandom_range(0, 1) == 1);
      wrtRegX = 3'($urandom_range(0, 3));
      srcAD = 3'($urandom_range(0, 3));
      srcBD = 3'($urandom_range(0, 3));
      srcAValidD = ($urandom_range(0, 3) != 0);
      srcBValidD = ($urandom_range(0, 1) == 1);
      branchTakenX = ($urandom_range(0, 7) == 0);
      haltD = ($urandom_range(0, 15) == 0);
      iMemStall = ($urandom_range(0, 3) == 0);
      dMemStall = ($urandom_range(0, 4) == 0);
      halt_age = m_halted ? halt_age + 1 : 0;
      if (halt_age > 3 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halt_age = 0;
      end else step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Sequences the five-stage pipeline registers (F/D, D/X, X/M, M/W) and the PC.
- Drives per-register enable and bubble/flush controls from four hazard sources: load-use in D, taken branch/jump resolved in X, multi-cycle data-memory stall and instruction-memory stall.
- Owns the halt drain sequence and saturating stall/flush performance counters.
- Sits beside the pipeline registers and is the single source of their enables.

Parameters:
- CNT_W, 16, width of each saturating performance counter.
- DRAIN_CYC, 3, advancing cycles between a halt leaving D and the halted flag (X, M, W).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- readEnX  in  1  instruction in X is a load.
- wrtRegX  in  3  destination register of instruction in X.
- srcAD  in  3  first source register of instruction in D.
- srcAValidD  in  1  srcAD is read.
- srcBD  in  3  second source register of instruction in D.
- srcBValidD  in  1  srcBD is read.
- branchTakenX  in  1  control transfer in X redirects PC.
- haltD  in  1  instruction in D is HALT.
- iMemStall  in  1  fetch not ready this cycle.
- dMemStall  in  1  data memory busy; pipeline must freeze.
- pcEn  out  1  PC register load enable.
- enFD  out  1  F/D register enable.
- flushFD  out  1  load NOP into F/D (valid only with enFD=1).
- enDX  out  1  D/X register enable.
- bubbleDX  out  1  load NOP into D/X (valid only with enDX=1).
- enXM  out  1  X/M register enable.
- enMW  out  1  M/W register enable.
- halted  out  1  registered; pipeline fully drained after HALT.
- stallCnt  out  CNT_W  load-use plus I-mem stall cycles, saturating.
- flushCnt  out  CNT_W  branch flush events, saturating.

Behaviour:
- Reset (async): state RUN, drain counter 0, halted 0, stallCnt 0, flushCnt 0.
- While rst is high, all enables and flush/bubble outputs are 0.
- States:
  - RUN.
  - DRAIN: 2-bit counter, loaded with DRAIN_CYC.
  - HALTED.
- Load-use hazard: luHaz = readEnX & ((srcAValidD & srcAD==wrtRegX) | (srcBValidD & srcBD==wrtRegX)).
- Base outputs in RUN: all enables 1, flush/bubble 0.
- RUN priority, highest first:
  1. dMemStall: pcEn, enFD, enDX, enXM and enMW all 0 (full freeze); no counter changes.
  2. branchTakenX: pcEn=1 (target), flushFD=1, bubbleDX=1, others 1; flushCnt++. Suppresses luHaz and haltD.
  3. luHaz: pcEn=0, enFD=0, bubbleDX=1; enDX, enXM, enMW=1; stallCnt++. Exactly one bubble; the hazard clears when the load leaves X.
  4. haltD with no luHaz: normal advance; next state DRAIN, counter=DRAIN_CYC.
  5. iMemStall: pcEn=0, flushFD=1, rest 1; stallCnt++.
  - A halt that is suppressed by a branch or held by luHaz does not enter DRAIN.
- iMemStall together with luHaz: the luHaz outputs win; stallCnt increments once.
- DRAIN:
  - Outputs: pcEn=0, enFD=1 with flushFD=1, enDX=1 with bubbleDX=1, enXM=1, enMW=1.
  - The counter decrements each non-frozen cycle.
  - dMemStall freezes everything, including the counter.
  - Counter reaching 0 moves to HALTED.
  - Branch and luHaz inputs are ignored.
- HALTED:
  - All enables 0, halted=1 (registered, asserted the first cycle in HALTED).
  - Only rst leaves this state.
- Counters: saturate at all-ones and never wrap; update on the clock edge of the qualifying cycle.
- Latency:
  - Enable/flush outputs are combinational from inputs and state, with zero-cycle latency.
  - halted, state and counters are registered.
- Reset mid-DRAIN or mid-freeze returns to RUN immediately (asynchronous).

Test Plan:
- Load with wrtRegX=3, srcAD=3, srcAValidD=1 -> one cycle pcEn=0, enFD=0, bubbleDX=1; next cycle (readEnX=0) all enables 1; stallCnt=1.
- branchTakenX=1 together with luHaz=1 -> pcEn=1, flushFD=1, bubbleDX=1, stallCnt unchanged, flushCnt=1.
- dMemStall high for 4 cycles during a load-use -> all enables 0 for 4 cycles, counters unchanged; load-use bubble issues on the release cycle.
- haltD=1 in RUN -> 3 DRAIN cycles with pcEn=0/flushFD=1; halted=1 on the 4th cycle; all enables 0 after. A 2-cycle dMemStall inside DRAIN delays halted by exactly 2 cycles.
- haltD=1 with branchTakenX=1 -> stays in RUN; halted remains 0.
- Force stallCnt to 0xFFFF via repeated iMemStall (CNT_W reduced to 4 for sim) -> holds 0xF. Assert rst mid-DRAIN -> state RUN, halted=0, counters 0 without a clock edge.
